// File: rtl/xbar_config_engine.sv
// Crossbar configuration engine: holds WORDS 16-bit config words on the EBI bus and
// streams them MSB-first into CHAINS serial chains, then pulses the active-low latch.
module xbar_config_engine #(
    parameter int POSITION = 0,
    parameter int WORDS    = 32,
    parameter int CHAINS   = 1
) (
    input  logic              ebi_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              re,
    input  logic              wr,
    input  logic [18:0]       addr,
    input  logic [15:0]       data,
    output logic [15:0]       data_out,
    output logic              xbar_clock,
    output logic              pclk,
    output logic [CHAINS-1:0] sin
);

    localparam int W = WORDS / CHAINS;

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, LATCH} state_t;

    state_t      state_q, state_d;
    logic [15:0] cfg_q [128];
    logic [15:0] cfg_d [128];
    logic [15:0] sr_q [CHAINS];
    logic [15:0] sr_d [CHAINS];
    logic [7:0]  div_q, div_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [6:0]  word_q, word_d;
    logic        done_q, done_d;
    logic [15:0] data_out_q, data_out_d;

    logic cs, busy, wr_cmd, start, abort, wr_div, wr_cfg, phase_end;

    assign cs        = enable && (addr[18:8] == 11'(POSITION));
    assign busy      = (state_q != IDLE);
    assign wr_cmd    = cs && wr && (addr[7:0] == 8'h01);
    assign start     = wr_cmd && data[0];
    assign abort     = wr_cmd && data[2];
    assign wr_div    = cs && wr && (addr[7:0] == 8'h02) && !busy;
    assign wr_cfg    = cs && wr && addr[7] && !busy && (int'(addr[6:0]) < WORDS);
    assign phase_end = (phase_q == div_q);

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        sr_d    = sr_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        word_d  = word_q;
        done_d  = done_q;

        if (wr_div) div_d = data[7:0];
        if (wr_cfg) cfg_d[addr[6:0]] = data;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    done_d  = 1'b0;
                end
            end
            LOAD: begin
                // Chain c takes words c, c+CHAINS, ... so word_q indexes within a chain
                for (int c = 0; c < CHAINS; c++)
                    sr_d[c] = cfg_q[7'(int'(word_q) * CHAINS + c)];
                phase_d = '0;
                state_d = SETUP;
            end
            SETUP: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = HIGH;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    phase_d = '0;
                    for (int c = 0; c < CHAINS; c++)
                        sr_d[c] = {sr_q[c][14:0], 1'b0};
                    if (bit_q == 4'd15) begin
                        bit_d = '0;
                        if (word_q == 7'(W - 1)) begin
                            state_d = LATCH;
                        end else begin
                            word_d  = word_q + 7'd1;
                            state_d = LOAD;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = SETUP;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            LATCH: begin
                if (phase_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    phase_d = '0;
                    bit_d   = '0;
                    word_d  = '0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a LATCH that would finish this cycle
        if (busy && abort) begin
            state_d = IDLE;
            done_d  = done_q;
            phase_d = '0;
            bit_d   = '0;
            word_d  = '0;
        end
    end

    always_comb begin
        data_out_d = '0;
        if (cs && re) begin
            if (addr[7:0] == 8'h09)      data_out_d = 16'h7ba3;
            else if (addr[7:0] == 8'h0A) data_out_d = {14'b0, done_q, busy};
        end
    end

    always_comb begin
        xbar_clock = 1'b0;
        pclk       = 1'b1;
        sin        = '0;
        if (state_q == SETUP || state_q == HIGH)
            for (int c = 0; c < CHAINS; c++) sin[c] = sr_q[c][15];
        if (state_q == HIGH)  xbar_clock = 1'b1;
        if (state_q == LATCH) pclk = 1'b0;
    end

    always_ff @(posedge ebi_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            phase_q    <= '0;
            bit_q      <= '0;
            word_q     <= '0;
            done_q     <= 1'b0;
            data_out_q <= '0;
            for (int i = 0; i < 128; i++) cfg_q[i] <= '0;
            for (int c = 0; c < CHAINS; c++) sr_q[c] <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            cfg_q      <= cfg_d;
            sr_q       <= sr_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: doc/xbar_config_engine.md
XBAR_CONFIG_ENGINE -- requirements
Module: xbar_config_engine

Interface
REQ-001 Parameter POSITION, default 0: block selected when enable=1 and addr[18:8]==POSITION.
REQ-002 Parameter WORDS, default 32: number of 16-bit config words; legal values 1..128.
REQ-003 Parameter CHAINS, default 1: parallel xbar serial chains; legal values 1, 2 or 4; WORDS is a multiple of CHAINS.
REQ-004 ebi_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  bus enable.
REQ-007 re  in  1  read strobe.
REQ-008 wr  in  1  write strobe.
REQ-009 addr  in  19  bus address.
REQ-010 data  in  16  write data.
REQ-011 data_out  out  16  registered read data.
REQ-012 xbar_clock  out  1  shift clock to all chains.
REQ-013 pclk  out  1  active-low latch pulse to all chains.
REQ-014 sin  out  CHAINS  serial data, one bit per chain.

Function
REQ-015 Register map (cs = enable & addr[18:8]==POSITION):
- addr[7]=1: config word addr[6:0]; write only; index >= WORDS ignored.
- 0x01 COMMAND (write): bit0 = start, bit2 = abort.
- 0x02 DIVIDE (write, 8 bits): DIV.
- 0x09 ID (read): 16'h7ba3.
- 0x0A STATUS (read): {14'b0, done, busy}.
REQ-016 data_out updates one cycle after cs&re with an ID/STATUS address; 0 on any other cycle or address.
REQ-017 Config and DIVIDE writes while busy=1 are ignored.
REQ-018 Chain c is sent words c, c+CHAINS, c+2*CHAINS, ... in ascending index; W = WORDS/CHAINS words per chain, MSB first.
REQ-019 FSM states: IDLE, LOAD, SETUP, HIGH, LATCH.
- IDLE -> LOAD: start write.
- LOAD -> SETUP after 1 cycle.
- SETUP -> HIGH after DIV+1 cycles.
- HIGH -> SETUP after DIV+1 cycles if more bits remain in the current word.
- HIGH -> LOAD after the 16th bit if words remain.
- HIGH -> LATCH after the last bit.
- LATCH -> IDLE after DIV+1 cycles.
REQ-020 Outputs by state:
- LOAD: shift register of every chain loaded from its next word.
- SETUP: xbar_clock=0; sin[c] = MSB of chain c shift register, stable for the whole SETUP and HIGH phases.
- HIGH: xbar_clock=1; shift registers shift left once on exit.
- LATCH: pclk=0.
- All other states: pclk=1, xbar_clock=0, sin=0.
REQ-021 busy=1 in every state except IDLE; asserted the cycle after the start write.
REQ-022 Busy duration is W*(1+32*(DIV+1)) + (DIV+1) cycles.
REQ-023 done is sticky: set on LATCH -> IDLE; cleared by a start write.
REQ-024 Start while busy is ignored.
REQ-025 Abort while busy forces IDLE next cycle: xbar_clock=0, pclk=1, sin=0, done unchanged, no LATCH pulse.
REQ-026 Simultaneous start and abort in the same write: abort wins.
REQ-027 Bit and word counters are sized for WORDS=128, DIV=255 without overflow and reset to 0 on every entry to IDLE.

Reset
REQ-028 While reset=0, asynchronously force:
- data_out=0, xbar_clock=0, pclk=1, sin=0.
- busy=0, done=0, DIV=0, state IDLE.
- all config words and shift registers cleared to 0.
REQ-029 Reset asserted mid-transfer aborts it with no pclk pulse; after release the block waits in IDLE for a new start.

Verification
REQ-030 WORDS=4, CHAINS=1, DIV=0, words 0x8001,0x0000,0xFFFF,0x1234, start -> 64 xbar_clock pulses; sin sampled at rising edges = the 64 bits MSB-first; one 1-cycle pclk low; busy high exactly 133 cycles; STATUS reads 0x0002.
REQ-031 Same words, DIV=3 -> xbar_clock high 4 / low 4 cycles; pclk low 4 cycles; busy 4*129+4 = 520 cycles.
REQ-032 WORDS=4, CHAINS=2, words 0xAAAA,0x5555,0x0F0F,0xF0F0 -> sin[0] carries 0xAAAA then 0x0F0F; sin[1] carries 0x5555 then 0xF0F0; 32 xbar_clock pulses.
REQ-033 Abort at cycle 20 of the REQ-030 transfer -> next cycle busy=0, done=0, no pclk low; a second start then completes normally.
REQ-034 During a transfer: write to config word 0, a second start, and a DIVIDE write -> all ignored; transmitted stream is unchanged.
REQ-035 Drive reset low mid-transfer -> outputs reach reset values without a clock edge; ID read after release returns 0x7ba3.
